// File: rtl/led_fade_pwm.sv
// LED fade stage: ramps a brightness level toward a ceiling while led_in is high
// and back to zero when it is low, driving the LED pin with a glitch-free PWM.
module led_fade_pwm #(
  parameter logic [31:0] STEP_CLKS = 32'd50000,
  parameter logic [7:0]  PWM_MAX   = 8'd255
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       led_in,
  input  logic [7:0] max_level,
  output logic       led_pwm,
  output logic [7:0] level,
  output logic       busy
);

  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;

  state_t      state, state_next;
  logic        led_in_q;
  logic [7:0]  target;
  logic [7:0]  level_next;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty;
  logic [31:0] step_timer;
  logic        step_tick;
  logic        pwm_wrap;
  logic        busy_next;

  always_comb begin
    target    = led_in_q ? max_level : '0;
    step_tick = (step_timer == STEP_CLKS - 32'd1);
    pwm_wrap  = (pwm_cnt == PWM_MAX - 8'd1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= OFF;
      level <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      level <= level_next;
      busy  <= busy_next;
    end
  end

  // A direction change takes priority over a pending step; steps compare in
  // 9 bits so the ramp clamps at the target without wrapping past 0 or 255.
  always_comb begin
    state_next = state;
    level_next = level;
    case (state)
      OFF: begin
        level_next = '0;
        if (target != '0) state_next = RAMP_UP;
      end
      RAMP_UP: begin
        if (target < level) begin
          state_next = RAMP_DOWN;
        end else if (step_tick) begin
          if ({1'b0, level} + 9'd1 >= {1'b0, target}) begin
            level_next = target;
            state_next = ON;
          end else begin
            level_next = level + 8'd1;
          end
        end
      end
      ON: begin
        if (target > level)      state_next = RAMP_UP;
        else if (target < level) state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (target > level) begin
          state_next = RAMP_UP;
        end else if (step_tick) begin
          if ({1'b0, level} <= {1'b0, target} + 9'd1) begin
            level_next = target;
            state_next = (target == '0) ? OFF : ON;
          end else begin
            level_next = level - 8'd1;
          end
        end
      end
      default: state_next = OFF;
    endcase
  end

  always_comb begin
    busy_next = (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_in_q <= 1'b0;
    end else begin
      led_in_q <= led_in;
    end
  end

  // Timer restarts on every state change so a ramp's first step is a full period away.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      step_timer <= '0;
    end else if (state_next != state || step_tick) begin
      step_timer <= '0;
    end else begin
      step_timer <= step_timer + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led_pwm <= 1'b0;
    end else begin
      pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + 8'd1;
      if (pwm_wrap) duty <= level;
      led_pwm <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: direction/elapsed-time reference model checked every
// cycle, plus directed scenarios with hand-computed expectations and random traffic.
module tb_led_fade_pwm;

  localparam int STEP = 4;
  localparam int PMAX = 255;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       led_in;
  logic [7:0] max_level;
  logic       led_pwm;
  logic [7:0] level;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  led_fade_pwm #(
    .STEP_CLKS(32'd4),
    .PWM_MAX  (8'd255)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .led_in   (led_in),
    .max_level(max_level),
    .led_pwm  (led_pwm),
    .level    (level),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference: brightness moves one count per STEP cycles in direction dir
  // (+1 up, -1 down, 0 settled); elapsed restarts whenever dir changes.
  typedef struct {
    int in_q;
    int lvl;
    int dir;
    int elapsed;
    int phase;
    int duty;
    int pwm;
    int busy;
  } mstate_t;

  mstate_t m = '{default: 0};

  function automatic mstate_t model_next(mstate_t c, int in_bit, int maxl);
    mstate_t n;
    int      tgt;
    bit      changed;
    n       = c;
    changed = 1'b0;
    tgt     = (c.in_q != 0) ? maxl : 0;
    n.pwm   = (c.phase < c.duty) ? 1 : 0;
    n.duty  = (c.phase == PMAX - 1) ? c.lvl : c.duty;
    n.phase = (c.phase + 1) % PMAX;
    if (c.dir == 0) begin
      if (tgt != c.lvl) begin
        n.dir   = (tgt > c.lvl) ? 1 : -1;
        changed = 1'b1;
      end
    end else if (c.dir * (tgt - c.lvl) < 0) begin
      n.dir   = -c.dir;
      changed = 1'b1;
    end else if (c.elapsed == STEP - 1) begin
      if ((c.dir == 1 && c.lvl + 1 >= tgt) || (c.dir == -1 && c.lvl - 1 <= tgt)) begin
        n.lvl   = tgt;
        n.dir   = 0;
        changed = 1'b1;
      end else begin
        n.lvl = c.lvl + c.dir;
      end
    end
    n.elapsed = changed ? 0 : (c.elapsed + 1) % STEP;
    n.busy    = (n.dir != 0) ? 1 : 0;
    n.in_q    = in_bit;
    return n;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) m <= '{default: 0};
    else            m <= model_next(m, int'(led_in), int'(max_level));
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      hi += int'(led_pwm);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    int bz;
    sys_rst_n = 1'b0;
    led_in    = 1'b0;
    max_level = 8'd0;

    fork
      forever begin
        @(negedge sys_clk);
        if (sys_rst_n) begin
          check("model_level", int'(level), m.lvl);
          check("model_busy", int'(busy), m.busy);
          check("model_pwm", int'(led_pwm), m.pwm);
        end
      end
    join_none

    tick(3);
    sys_rst_n = 1'b1;
    tick(1);
    check("reset_level", int'(level), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pwm", int'(led_pwm), 0);

    // ramp up to 8
    max_level = 8'd8;
    led_in    = 1'b1;
    tick(2);
    check("up_busy_rise", int'(busy), 1);
    check("up_level_start", int'(level), 0);
    tick(4);
    check("up_first_step", int'(level), 1);
    tick(28);
    check("up_level_final", int'(level), 8);
    check("up_busy_done", int'(busy), 0);
    tick(300);
    count_high(255, hi);
    check("up_pwm_duty8", hi, 8);

    // reversal at level 5
    led_in = 1'b0;
    tick(40);
    led_in = 1'b1;
    tick(22);
    check("rev_level5", int'(level), 5);
    led_in = 1'b0;
    tick(2);
    check("rev_busy", int'(busy), 1);
    check("rev_level_hold", int'(level), 5);
    tick(20);
    check("rev_level0", int'(level), 0);
    check("rev_busy_done", int'(busy), 0);
    tick(260);
    count_high(255, hi);
    check("rev_pwm_zero", hi, 0);

    // full scale
    max_level = 8'd255;
    led_in    = 1'b1;
    tick(1022);
    check("full_level", int'(level), 255);
    check("full_busy", int'(busy), 0);
    tick(260);
    count_high(255, hi);
    check("full_pwm_const1", hi, 255);
    led_in = 1'b0;
    tick(1030);

    // zero ceiling
    max_level = 8'd0;
    led_in    = 1'b1;
    bz = 0;
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      bz += int'(busy);
      hi += int'(led_pwm);
    end
    check("zero_busy_never", bz, 0);
    check("zero_pwm", hi, 0);
    check("zero_level", int'(level), 0);

    // ceiling change 200 -> 100
    max_level = 8'd200;
    tick(802);
    check("ceil_level200", int'(level), 200);
    check("ceil_busy200", int'(busy), 0);
    tick(300);
    max_level = 8'd100;
    tick(1);
    check("ceil_busy_down", int'(busy), 1);
    tick(400);
    check("ceil_level100", int'(level), 100);
    check("ceil_busy_done", int'(busy), 0);
    tick(300);
    count_high(510, hi);
    check("ceil_pwm_duty100", hi, 200);

    // async reset mid ramp at level 6
    led_in = 1'b0;
    tick(410);
    max_level = 8'd8;
    led_in    = 1'b1;
    tick(26);
    check("rst_pre_level6", int'(level), 6);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_level", int'(level), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_pwm", int'(led_pwm), 0);
    led_in = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    count_high(300, hi);
    check("rst_after_pwm", hi, 0);
    check("rst_after_level", int'(level), 0);

    // random traffic against the model
    for (int k = 0; k < 60; k++) begin
      led_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) max_level = 8'($urandom_range(0, 255));
      else                           max_level = 8'($urandom_range(0, 12));
      tick(int'($urandom_range(1, 80)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
